// File: rtl/snn_decoder_pkg.sv
// Shared types and helpers for the spike-rate decoder.
package snn_decoder_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        COUNT  = 2'd1,
        DECIDE = 2'd2,
        HOLD   = 2'd3
    } dec_state_t;

    localparam int unsigned DEFAULT_CNT_W = 8;

    // Class index width; a single-neuron build still gets a 1-bit index.
    function automatic int unsigned class_idx_w(input int unsigned n_output);
        return (n_output > 1) ? $clog2(n_output) : 1;
    endfunction

endpackage

// File: rtl/spike_argmax.sv
// Combinational argmax over the per-neuron spike counters; lowest index wins ties.
// Optional tie detect when SNN_DECODER_TIE_EN is defined.
module spike_argmax
    import snn_decoder_pkg::*;
#(
    parameter int unsigned N_OUTPUT = 3,
    parameter int unsigned CNT_W    = DEFAULT_CNT_W,
    localparam int unsigned IDX_W   = class_idx_w(N_OUTPUT)
) (
    input  logic [CNT_W-1:0] counts [N_OUTPUT],
    output logic [IDX_W-1:0] max_idx_c,
    output logic [CNT_W-1:0] max_cnt_c,
`ifdef SNN_DECODER_TIE_EN
    output logic             tie_c,
`endif
    output logic             none_c
);

    // Strict greater-than keeps the earliest index on equal counts
    always_comb begin
        max_idx_c = '0;
        max_cnt_c = counts[0];
        for (int unsigned j = 1; j < N_OUTPUT; j++) begin
            if (counts[j] > max_cnt_c) begin
                max_idx_c = IDX_W'(j);
                max_cnt_c = counts[j];
            end
        end
    end

    assign none_c = (max_cnt_c == '0);

`ifdef SNN_DECODER_TIE_EN
    logic seen_max;
    logic tie_any;

    // Two or more neurons sharing a nonzero maximum
    always_comb begin
        seen_max = 1'b0;
        tie_any  = 1'b0;
        for (int unsigned j = 0; j < N_OUTPUT; j++) begin
            if (counts[j] == max_cnt_c) begin
                if (seen_max) begin
                    tie_any = 1'b1;
                end
                seen_max = 1'b1;
            end
        end
    end

    assign tie_c = tie_any & ~none_c;
`endif

endmodule

// File: rtl/spike_rate_decoder.sv
// Rate-coded classifier: counts L2 spikes per neuron over a window and
// reports the most active neuron with a valid/ready handshake.
// Optional macro SNN_DECODER_TIE_EN adds the tie_flag output.
module spike_rate_decoder
    import snn_decoder_pkg::*;
#(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned N_OUTPUT = 3,
    parameter int unsigned CNT_W    = DEFAULT_CNT_W,
    localparam int unsigned IDX_W   = class_idx_w(N_OUTPUT)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [WIDTH-1:0] window_len,
    input  logic             spike_L2 [N_OUTPUT],
    input  logic             class_ready,
    output logic             class_valid,
    output logic [IDX_W-1:0] class_idx,
    output logic             no_spike,
`ifdef SNN_DECODER_TIE_EN
    output logic             tie_flag,
`endif
    output logic [CNT_W-1:0] win_count
);

    dec_state_t       state;
    dec_state_t       state_nxt;
    logic [WIDTH-1:0] len_q;
    logic [WIDTH-1:0] cyc_q;
    logic [WIDTH-1:0] last_cyc_c;
    logic [CNT_W-1:0] cnt_q [N_OUTPUT];

    logic             handshake_c;
    logic             start_c;
    logic             count_c;
    logic             decide_c;
    logic             valid_nxt_c;

    logic [IDX_W-1:0] max_idx_c;
    logic [CNT_W-1:0] max_cnt_c;
    logic             none_c;
`ifdef SNN_DECODER_TIE_EN
    logic             tie_c;
`endif

    // A zero window length behaves as a one-cycle window
    assign last_cyc_c  = (len_q == '0) ? '0 : len_q - WIDTH'(1);
    assign handshake_c = class_valid & class_ready;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; enable only matters in IDLE and at the handshake
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (enable) state_nxt = COUNT;
            COUNT:   if (cyc_q == last_cyc_c) state_nxt = DECIDE;
            DECIDE:  state_nxt = HOLD;
            HOLD:    if (handshake_c) state_nxt = enable ? COUNT : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Control strobes derived from the current and next state
    always_comb begin
        start_c     = (state_nxt == COUNT) && (state != COUNT);
        count_c     = (state == COUNT);
        decide_c    = (state == DECIDE);
        valid_nxt_c = (state_nxt == HOLD);
    end

    // Window length latch and elapsed-cycle counter
    always_ff @(posedge clk) begin
        if (rst) begin
            len_q <= '0;
            cyc_q <= '0;
        end else if (start_c) begin
            len_q <= window_len;
            cyc_q <= '0;
        end else if (count_c) begin
            cyc_q <= cyc_q + WIDTH'(1);
        end
    end

    // Saturating per-neuron spike counters, live only in COUNT
    always_ff @(posedge clk) begin
        for (int unsigned j = 0; j < N_OUTPUT; j++) begin
            if (rst || start_c) begin
                cnt_q[j] <= '0;
            end else if (count_c && spike_L2[j] && (cnt_q[j] != '1)) begin
                cnt_q[j] <= cnt_q[j] + CNT_W'(1);
            end
        end
    end

    spike_argmax #(
        .N_OUTPUT (N_OUTPUT),
        .CNT_W    (CNT_W)
    ) u_argmax (
        .counts    (cnt_q),
        .max_idx_c (max_idx_c),
        .max_cnt_c (max_cnt_c),
`ifdef SNN_DECODER_TIE_EN
        .tie_c     (tie_c),
`endif
        .none_c    (none_c)
    );

    // Result registers: captured in DECIDE, held through HOLD
    always_ff @(posedge clk) begin
        if (rst) begin
            class_valid <= 1'b0;
            class_idx   <= '0;
            win_count   <= '0;
            no_spike    <= 1'b0;
        end else begin
            class_valid <= valid_nxt_c;
            if (decide_c) begin
                class_idx <= max_idx_c;
                win_count <= max_cnt_c;
                no_spike  <= none_c;
            end
        end
    end

`ifdef SNN_DECODER_TIE_EN
    // Tie indication, captured alongside the result
    always_ff @(posedge clk) begin
        if (rst) begin
            tie_flag <= 1'b0;
        end else if (decide_c) begin
            tie_flag <= tie_c;
        end
    end
`endif

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Self-checking bench for spike_rate_decoder: directed and randomized windows
// checked against a counting/argmax reference model.
module tb_spike_rate_decoder;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned N     = 3;
    localparam int unsigned CNT_W = 8;
    localparam int unsigned IDX_W = 2;
    localparam int unsigned SAT   = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             enable;
    logic [WIDTH-1:0] window_len;
    logic             spike_L2 [N];
    logic             class_ready;
    logic             class_valid;
    logic [IDX_W-1:0] class_idx;
    logic             no_spike;
    logic [CNT_W-1:0] win_count;
`ifdef SNN_DECODER_TIE_EN
    logic             tie_flag;
`endif

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    logic [N-1:0] pat [$];
    int unsigned  exp_idx;
    int unsigned  exp_cnt;
    int unsigned  exp_none;
    int unsigned  exp_tie;

    always #5 clk = ~clk;

    spike_rate_decoder #(
        .WIDTH    (WIDTH),
        .N_OUTPUT (N),
        .CNT_W    (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .window_len  (window_len),
        .spike_L2    (spike_L2),
        .class_ready (class_ready),
        .class_valid (class_valid),
        .class_idx   (class_idx),
        .no_spike    (no_spike),
`ifdef SNN_DECODER_TIE_EN
        .tie_flag    (tie_flag),
`endif
        .win_count   (win_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_spikes(input logic [N-1:0] v);
        for (int j = 0; j < N; j++) spike_L2[j] = v[j];
    endtask

    // Reference: per-neuron totals clipped at SAT, winner is the first neuron holding the max
    task automatic model(input int unsigned tot [N]);
        int unsigned m;
        int unsigned nmax;
        m = 0;
        for (int j = 0; j < N; j++) begin
            if (tot[j] > SAT) tot[j] = SAT;
            if (tot[j] > m) m = tot[j];
        end
        exp_idx = 0;
        nmax    = 0;
        for (int j = N - 1; j >= 0; j--) begin
            if (tot[j] == m) begin
                exp_idx = j;
                nmax++;
            end
        end
        exp_cnt  = m;
        exp_none = (m == 0) ? 1 : 0;
        exp_tie  = (nmax >= 2 && m != 0) ? 1 : 0;
    endtask

    task automatic check_result(input string tag);
        check({tag, "/valid"}, 32'(class_valid), 1);
        check({tag, "/idx"}, 32'(class_idx), exp_idx);
        check({tag, "/count"}, 32'(win_count), exp_cnt);
        check({tag, "/no_spike"}, 32'(no_spike), exp_none);
`ifdef SNN_DECODER_TIE_EN
        check({tag, "/tie"}, 32'(tie_flag), exp_tie);
`endif
    endtask

    // Starts a window (from IDLE or via handshake in HOLD), plays pat, ends in HOLD
    task automatic run_window(input int unsigned wl, input logic [WIDTH-1:0] noise_len,
                              input string tag);
        int unsigned  len;
        int unsigned  tot [N];
        logic         seen_valid;
        logic [N-1:0] v;
        len         = (wl == 0) ? 1 : wl;
        enable      = 1'b1;
        window_len  = WIDTH'(wl);
        class_ready = 1'b1;
        drive_spikes(N'($urandom));
        tick();
        check({tag, "/valid_drop"}, 32'(class_valid), 0);
        class_ready = 1'b0;
        window_len  = noise_len;
        enable      = 1'($urandom);
        for (int j = 0; j < N; j++) tot[j] = 0;
        seen_valid = 1'b0;
        for (int unsigned i = 0; i < len; i++) begin
            v = (i < pat.size()) ? pat[i] : '0;
            drive_spikes(v);
            for (int j = 0; j < N; j++) if (v[j]) tot[j]++;
            if (class_valid !== 1'b0) seen_valid = 1'b1;
            tick();
        end
        drive_spikes(N'($urandom));
        if (class_valid !== 1'b0) seen_valid = 1'b1;
        check({tag, "/valid_early"}, 32'(seen_valid), 0);
        tick();
        model(tot);
        check_result(tag);
        enable = 1'b0;
    endtask

    initial begin
        logic         seen;
        logic [N-1:0] v;
        int unsigned  wl;

        rst         = 1'b1;
        enable      = 1'b0;
        class_ready = 1'b0;
        window_len  = '0;
        drive_spikes('0);
        tick();
        tick();
        check("reset/valid", 32'(class_valid), 0);
        check("reset/idx", 32'(class_idx), 0);
        check("reset/count", 32'(win_count), 0);
        check("reset/no_spike", 32'(no_spike), 0);
        rst = 1'b0;
        tick();

        // Basic: neuron 1 on 7 cycles, neuron 0 on 3, neuron 2 silent
        pat.delete();
        for (int i = 0; i < 10; i++) begin
            v = '0;
            if (i < 7) v[1] = 1'b1;
            else       v[0] = 1'b1;
            pat.push_back(v);
        end
        run_window(10, 16'd10, "basic");
        check("basic/exp_idx1", 32'(class_idx), 1);
        check("basic/exp_cnt7", 32'(win_count), 7);

        // Backpressure: result must hold while ready is low
        for (int k = 0; k < 5; k++) begin
            class_ready = 1'b0;
            enable      = 1'($urandom);
            drive_spikes(N'($urandom));
            tick();
            check_result("stall");
        end

        // Tie 4,4,2 resolves to neuron 0
        pat.delete();
        for (int i = 0; i < 6; i++) begin
            v = '0;
            if (i < 4) v[1:0] = 2'b11;
            if (i < 2) v[2] = 1'b1;
            pat.push_back(v);
        end
        run_window(6, 16'd2, "tie");
        check("tie/exp_idx0", 32'(class_idx), 0);

        // Handshake with enable low returns to IDLE and stays quiet
        class_ready = 1'b1;
        enable      = 1'b0;
        tick();
        check("to_idle/valid", 32'(class_valid), 0);
        class_ready = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            drive_spikes(N'($urandom));
            tick();
            if (class_valid !== 1'b0) seen = 1'b1;
        end
        check("idle/no_valid", 32'(seen), 0);

        // Empty window with length 0
        pat.delete();
        run_window(0, 16'd5, "empty");
        check("empty/exp_none", 32'(no_spike), 1);

        // Saturation: neuron 2 high for 300 cycles
        pat.delete();
        for (int i = 0; i < 300; i++) begin
            v    = N'($urandom);
            v[2] = 1'b1;
            pat.push_back(v);
        end
        run_window(300, 16'd7, "sat");
        check("sat/exp_cnt255", 32'(win_count), 255);

        // Window length changed mid-window, then the new length applies
        pat.delete();
        for (int i = 0; i < 10; i++) pat.push_back(N'($urandom));
        run_window(10, 16'd3, "wchg10");
        pat.delete();
        for (int i = 0; i < 3; i++) pat.push_back(N'($urandom));
        run_window(3, 16'd10, "wchg3");

        // Reset at cycle 5 of a 10-cycle window
        class_ready = 1'b1;
        enable      = 1'b1;
        window_len  = 16'd10;
        tick();
        class_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            drive_spikes(3'b111);
            tick();
        end
        rst    = 1'b1;
        enable = 1'b0;
        tick();
        rst = 1'b0;
        check("midrst/valid", 32'(class_valid), 0);
        check("midrst/idx", 32'(class_idx), 0);
        check("midrst/count", 32'(win_count), 0);
        seen = 1'b0;
        for (int k = 0; k < 15; k++) begin
            drive_spikes(N'($urandom));
            tick();
            if (class_valid !== 1'b0) seen = 1'b1;
        end
        check("midrst/no_result", 32'(seen), 0);

        // Randomized windows with random stalls
        for (int w = 0; w < 6; w++) begin
            wl = $urandom_range(0, 20);
            pat.delete();
            for (int i = 0; i < 20; i++) pat.push_back(N'($urandom));
            run_window(wl, WIDTH'($urandom_range(0, 30)), $sformatf("rnd%0d", w));
            for (int k = 0; k < int'($urandom_range(0, 3)); k++) begin
                drive_spikes(N'($urandom));
                tick();
                check_result($sformatf("rnd%0d_stall", w));
            end
        end

        class_ready = 1'b1;
        enable      = 1'b0;
        tick();
        check("final/valid", 32'(class_valid), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
